button_debouncer: RTL and testbench

//  Conditions the raw devboard push-buttons before they reach the core's MMIO input port 4, bits [3:0].
//  Per button: 2-flop synchronizer, then a stability-counter debouncer.

---
 rtl/button_debouncer.sv | 76 +++++++
 tb/tb_button_debouncer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: per-channel two-flop synchronizer followed by a
// stability-counter debouncer, with press/release pulses and a sticky press flag.
module button_debouncer #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttonRaw,
  input  logic [NUM_BUTTONS-1:0] clearSticky,
  output logic [NUM_BUTTONS-1:0] buttonStable,
  output logic [NUM_BUTTONS-1:0] buttonPressed,
  output logic [NUM_BUTTONS-1:0] buttonReleased,
  output logic [NUM_BUTTONS-1:0] pressedSticky
);

  localparam int                   CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] stable_q, stable_d;
  logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
  logic [NUM_BUTTONS-1:0] released_q, released_d;
  logic [NUM_BUTTONS-1:0] sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_BUTTONS];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    stable_d   = stable_q;
    pressed_d  = '0;
    released_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i]   = sync2_q[i];
          pressed_d[i]  = sync2_q[i];
          released_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // A press accepted on the same edge as a clear wins.
    sticky_d = (sticky_q & ~clearSticky) | pressed_d;
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      sticky_q   <= '0;
      // NOTE: the counters are reset too; a partial count must not survive reset.
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= buttonRaw;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      sticky_q   <= sticky_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign buttonStable   = stable_q;
  assign buttonPressed  = pressed_q;
  assign buttonReleased = released_q;
  assign pressedSticky  = sticky_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: DEBOUNCE_CYCLES=4 main instance and a
// DEBOUNCE_CYCLES=1 instance for the minimum-latency case.
module tb_button_debouncer;

  logic       clock = 1'b0;
  logic       reset, reset1;
  logic [3:0] raw, clr, raw1, clr1;
  logic [3:0] stable, pressed, released, sticky;
  logic [3:0] stable1, pressed1, released1, sticky1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  button_debouncer #(.NUM_BUTTONS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .buttonRaw(raw), .clearSticky(clr),
    .buttonStable(stable), .buttonPressed(pressed),
    .buttonReleased(released), .pressedSticky(sticky)
  );

  button_debouncer #(.NUM_BUTTONS(4), .DEBOUNCE_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset1), .buttonRaw(raw1), .clearSticky(clr1),
    .buttonStable(stable1), .buttonPressed(pressed1),
    .buttonReleased(released1), .pressedSticky(sticky1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; pulses must be exclusive.
  task automatic step();
    @(posedge clock);
    #1;
    check("excl", 32'(pressed & released), 32'h0);
  endtask

  int bpat [6] = '{1, 0, 1, 1, 0, 1};
  int rpat [6] = '{0, 1, 0, 0, 1, 0};
  int np, nr, pstep, rstep;
  logic glitch_seen;

  initial begin
    reset = 1'b1; raw = '0; clr = '0;
    reset1 = 1'b1; raw1 = '0; clr1 = '0;

    // Reset with all buttons held
    raw = 4'hF;
    step(); step();
    check("rst_stable",   32'(stable),   32'h0);
    check("rst_pressed",  32'(pressed),  32'h0);
    check("rst_released", 32'(released), 32'h0);
    check("rst_sticky",   32'(sticky),   32'h0);
    reset = 1'b0;
    repeat (5) step();
    check("t1_stable_early", 32'(stable), 32'h0);
    step();
    check("t1_stable",  32'(stable),  32'hF);
    check("t1_pressed", 32'(pressed), 32'hF);
    step();
    check("t1_pulse_end", 32'(pressed), 32'h0);
    check("t1_sticky",    32'(sticky),  32'hF);
    raw = 4'h0;
    repeat (5) step();
    check("t1_rel_early", 32'(stable), 32'hF);
    step();
    check("t1_rel_stable",   32'(stable),   32'h0);
    check("t1_rel_released", 32'(released), 32'hF);
    step();
    check("t1_rel_pulse_end", 32'(released), 32'h0);
    clr = 4'hF; step(); clr = 4'h0;
    check("t1_sticky_clr", 32'(sticky), 32'h0);
    step();
    check("t1_clr_zero_noop", 32'(sticky), 32'h0);

    // Latency on channel 0
    raw[0] = 1'b1;
    repeat (5) step();
    check("t2_edge4_stable", 32'(stable[0]), 32'h0);
    step();
    check("t2_edge5_stable",  32'(stable[0]),  32'h1);
    check("t2_edge5_pressed", 32'(pressed[0]), 32'h1);
    step();
    check("t2_pulse_end", 32'(pressed[0]), 32'h0);
    check("t2_sticky",    32'(sticky[0]),  32'h1);
    repeat (3) step();
    check("t2_sticky_hold", 32'(sticky[0]), 32'h1);

    // Glitch on channel 1: 3-cycle pulse rejected, 4-cycle accepted
    glitch_seen = 1'b0;
    raw[1] = 1'b1;
    repeat (3) begin step(); glitch_seen |= stable[1] | pressed[1] | sticky[1]; end
    raw[1] = 1'b0;
    repeat (8) begin step(); glitch_seen |= stable[1] | pressed[1] | sticky[1]; end
    check("t3_glitch", 32'(glitch_seen), 32'h0);
    raw[1] = 1'b1;
    repeat (4) step();
    raw[1] = 1'b0;
    step();
    check("t3_hold_early", 32'(stable[1]), 32'h0);
    step();
    check("t3_hold_stable",  32'(stable[1]),  32'h1);
    check("t3_hold_pressed", 32'(pressed[1]), 32'h1);
    repeat (8) step();
    check("t3_released", 32'(stable[1]), 32'h0);
    check("t3_ch0_indep", 32'(stable[0]), 32'h1);

    // Press and release bounce on channel 2
    np = 0; nr = 0; pstep = -1;
    for (int i = 0; i < 6; i++) begin
      raw[2] = bpat[i][0];
      step();
      np += 32'(pressed[2]); nr += 32'(released[2]);
      if (pressed[2]) pstep = i - 4;
    end
    for (int k = 2; k <= 12; k++) begin
      step();
      np += 32'(pressed[2]); nr += 32'(released[2]);
      if (pressed[2]) pstep = k;
    end
    check("t4_press_count", 32'(np), 32'd1);
    check("t4_press_step",  32'(pstep), 32'd6);
    check("t4_press_norel", 32'(nr), 32'd0);
    np = 0; nr = 0; rstep = -1;
    for (int i = 0; i < 6; i++) begin
      raw[2] = rpat[i][0];
      step();
      np += 32'(pressed[2]); nr += 32'(released[2]);
      if (released[2]) rstep = i - 4;
    end
    for (int k = 2; k <= 12; k++) begin
      step();
      np += 32'(pressed[2]); nr += 32'(released[2]);
      if (released[2]) rstep = k;
    end
    check("t4_rel_count",   32'(nr), 32'd1);
    check("t4_rel_step",    32'(rstep), 32'd6);
    check("t4_rel_nopress", 32'(np), 32'd0);

    // Sticky set/clear race on channel 3
    raw[3] = 1'b1;
    repeat (5) step();
    check("t5_pre_sticky", 32'(sticky[3]), 32'h0);
    clr[3] = 1'b1;
    step();
    check("t5_race_pressed", 32'(pressed[3]), 32'h1);
    check("t5_race_sticky",  32'(sticky[3]),  32'h1);
    step();
    check("t5_clear_next", 32'(sticky[3]), 32'h0);
    clr[3] = 1'b0;
    step();
    check("t5_stays_clear", 32'(sticky[3]), 32'h0);

    // Mid-debounce reset on channel 0
    raw = 4'h0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_all", 32'({stable, pressed, released, sticky}), 32'h0);
    raw[0] = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_stable", 32'(stable), 32'h0);
    repeat (5) step();
    check("t6_early", 32'(stable[0]), 32'h0);
    step();
    check("t6_stable",  32'(stable[0]),  32'h1);
    check("t6_pressed", 32'(pressed[0]), 32'h1);

    // DEBOUNCE_CYCLES=1: latency of 3 edges after reset release
    check("d1_rst", 32'({stable1, pressed1, released1, sticky1}), 32'h0);
    reset1 = 1'b0; raw1 = 4'b0101;
    step(); step();
    check("d1_early", 32'(stable1), 32'h0);
    step();
    check("d1_stable",  32'(stable1),  32'h5);
    check("d1_pressed", 32'(pressed1), 32'h5);
    step();
    check("d1_pulse_end", 32'(pressed1), 32'h0);
    check("d1_sticky",    32'(sticky1),  32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
